// File: rtl/axis_gain_sequencer_pkg.sv
// Shared definitions for the gain sequencer: FSM state encodings, unity gain
// and the switch-to-gain scale constant.
package axis_gain_sequencer_pkg;

  typedef logic [1:0] gain_state_t;

  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd2;

  function automatic logic [63:0] gain_unity(input int gain_w);
    return 64'd1 << gain_w;
  endfunction

  // floor((2^gain_w - 1) / (2^sw_w - 1)); all-ones switches map to unity separately
  function automatic logic [63:0] sw_gain_scale(input int sw_w, input int gain_w);
    return ((64'd1 << gain_w) - 64'd1) / ((64'd1 << sw_w) - 64'd1);
  endfunction

endpackage

// File: rtl/axis_gain_sequencer_if.sv
// Monitored AXIS handshake of the volume block slave side.
interface axis_gain_sequencer_if;

  logic frame_valid;
  logic frame_ready;
  logic frame_last;

  modport master (
    output frame_valid,
    output frame_ready,
    output frame_last
  );

  modport slave (
    input frame_valid,
    input frame_ready,
    input frame_last
  );

endinterface

// File: rtl/axis_gain_sequencer_sync_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the input after DEBOUNCE_CYCLES identical synchronised samples.
module sync_debouncer #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] r_sync_p0;
  logic [WIDTH-1:0] r_sync_p1;
  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_db;
  logic             w_same;

  assign w_same = (r_sync_p1 == r_cand);
  assign o_dout = r_db;

  // stage p0/p1: metastability filter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= i_din;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // stability counter: a new candidate counts as its own first sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_db   <= '0;
    end else if (!w_same) begin
      r_cand <= r_sync_p1;
      r_cnt  <= CW'(1);
      if (DEBOUNCE_CYCLES == 1)
        r_db <= r_sync_p1;
    end else begin
      if (r_cnt != CW'(DEBOUNCE_CYCLES))
        r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(DEBOUNCE_CYCLES - 1))
        r_db <= r_cand;
    end
  end

endmodule

// File: rtl/axis_gain_sequencer.sv
// Gain sequencer: debounced volume/mute controls set a target, and the applied
// gain ramps toward it by a fixed step once per completed AXIS frame.
module axis_gain_sequencer
  import axis_gain_sequencer_pkg::*;
#(
  parameter int          SWITCH_WIDTH    = 4,
  parameter int          GAIN_WIDTH      = 24,
  parameter int unsigned RAMP_STEP       = 32'h100000,
  parameter int          DEBOUNCE_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SWITCH_WIDTH-1:0] sw,
  input  logic                    mute_btn,
  axis_gain_sequencer_if.slave    s_axis,
  output logic [GAIN_WIDTH:0]     gain,
  output logic                    gain_update,
  output logic                    muted,
  output logic                    ramping
);

  localparam int GW1 = GAIN_WIDTH + 1;
  localparam int AW  = GAIN_WIDTH + 2;

  localparam logic [GAIN_WIDTH:0]     GAIN_UNITY = GW1'(gain_unity(GAIN_WIDTH));
  localparam logic [GAIN_WIDTH:0]     SW_SCALE   = GW1'(sw_gain_scale(SWITCH_WIDTH, GAIN_WIDTH));
  localparam logic signed [AW-1:0]    STEP_S     = AW'(RAMP_STEP);

  logic [SWITCH_WIDTH-1:0] w_sw_db;
  logic                    w_mute_db;
  logic                    w_mute_rise;
  logic                    w_frame_end;
  logic [GAIN_WIDTH:0]     w_sw_ext;
  logic [GAIN_WIDTH:0]     w_eff_nxt;
  logic [GAIN_WIDTH:0]     w_gain_nxt;
  logic [1:0]              w_state_nxt;

  logic                    r_mute_db_d;
  logic                    r_muted;
  logic [GAIN_WIDTH:0]     r_sw_target_p0;
  logic [GAIN_WIDTH:0]     r_eff_target_p1;
  logic [GAIN_WIDTH:0]     r_gain_p2;
  logic [1:0]              r_state;
  logic                    r_gain_update;
  logic                    r_ramping;

  // Wide signed step with clamp to the target before truncation, so the
  // result can neither wrap nor cross the target.
  function automatic logic [GAIN_WIDTH:0] step_up_sat(input logic [GAIN_WIDTH:0] g,
                                                      input logic [GAIN_WIDTH:0] t);
    logic signed [AW-1:0] sum;
    sum = signed'({1'b0, g}) + STEP_S;
    if (sum >= signed'({1'b0, t}))
      return t;
    return GW1'(sum);
  endfunction

  function automatic logic [GAIN_WIDTH:0] step_down_sat(input logic [GAIN_WIDTH:0] g,
                                                        input logic [GAIN_WIDTH:0] t);
    logic signed [AW-1:0] diff;
    diff = signed'({1'b0, g}) - STEP_S;
    if (diff <= signed'({1'b0, t}))
      return t;
    return GW1'(diff);
  endfunction

  sync_debouncer #(
    .WIDTH           (SWITCH_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk    (clk),
    .reset  (reset),
    .i_din  (sw),
    .o_dout (w_sw_db)
  );

  sync_debouncer #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_mute_db (
    .clk    (clk),
    .reset  (reset),
    .i_din  (mute_btn),
    .o_dout (w_mute_db)
  );

  assign w_mute_rise = w_mute_db & ~r_mute_db_d;
  assign w_frame_end = s_axis.frame_valid & s_axis.frame_ready & s_axis.frame_last;
  assign w_sw_ext    = GW1'(w_sw_db);
  assign w_eff_nxt   = r_muted ? '0 : r_sw_target_p0;

  // stage p0: mute toggle and switch-to-target conversion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mute_db_d    <= 1'b0;
      r_muted        <= 1'b0;
      r_sw_target_p0 <= '0;
    end else begin
      r_mute_db_d    <= w_mute_db;
      r_muted        <= r_muted ^ w_mute_rise;
      r_sw_target_p0 <= (&w_sw_db) ? GAIN_UNITY : w_sw_ext * SW_SCALE;
    end
  end

  // Direction changes and leaving HOLD consume a frame without stepping.
  always_comb begin
    w_gain_nxt  = r_gain_p2;
    w_state_nxt = r_state;
    if (w_frame_end) begin
      case (r_state)
        ST_HOLD: begin
          if (r_gain_p2 < r_eff_target_p1)
            w_state_nxt = ST_RAMP_UP;
          else if (r_gain_p2 > r_eff_target_p1)
            w_state_nxt = ST_RAMP_DOWN;
        end
        ST_RAMP_UP: begin
          if (r_eff_target_p1 < r_gain_p2)
            w_state_nxt = ST_RAMP_DOWN;
          else if (r_eff_target_p1 == r_gain_p2)
            w_state_nxt = ST_HOLD;
          else begin
            w_gain_nxt = step_up_sat(r_gain_p2, r_eff_target_p1);
            if (w_gain_nxt == r_eff_target_p1)
              w_state_nxt = ST_HOLD;
          end
        end
        ST_RAMP_DOWN: begin
          if (r_eff_target_p1 > r_gain_p2)
            w_state_nxt = ST_RAMP_UP;
          else if (r_eff_target_p1 == r_gain_p2)
            w_state_nxt = ST_HOLD;
          else begin
            w_gain_nxt = step_down_sat(r_gain_p2, r_eff_target_p1);
            if (w_gain_nxt == r_eff_target_p1)
              w_state_nxt = ST_HOLD;
          end
        end
        default: w_state_nxt = ST_HOLD;
      endcase
    end
  end

  // stage p1/p2: effective target, applied gain and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_eff_target_p1 <= '0;
      r_gain_p2       <= '0;
      r_state         <= ST_HOLD;
      r_gain_update   <= 1'b0;
      r_ramping       <= 1'b0;
    end else begin
      r_eff_target_p1 <= w_eff_nxt;
      r_gain_p2       <= w_gain_nxt;
      r_state         <= w_state_nxt;
      r_gain_update   <= (w_gain_nxt != r_gain_p2);
      r_ramping       <= (w_gain_nxt != w_eff_nxt);
    end
  end

  assign gain        = r_gain_p2;
  assign gain_update = r_gain_update;
  assign muted       = r_muted;
  assign ramping     = r_ramping;

endmodule

// File: tb/tb_axis_gain_sequencer.sv
// Self-checking bench for axis_gain_sequencer: directed sequences, a target
// table and randomized traffic against a frame-level reference model.
module tb_axis_gain_sequencer;

  localparam int SW   = 4;
  localparam int GW   = 24;
  localparam int STEP = 'h100000;
  localparam int DC   = 4;
  localparam longint UNITY = 64'h1000000;

  typedef struct {
    logic [SW-1:0] sw;
    logic [GW:0]   exp_gain;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sw;
  logic          mute_btn;
  logic [GW:0]   gain;
  logic          gain_update;
  logic          muted;
  logic          ramping;

  axis_gain_sequencer_if mon ();

  axis_gain_sequencer #(
    .SWITCH_WIDTH    (SW),
    .GAIN_WIDTH      (GW),
    .RAMP_STEP       (STEP),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw          (sw),
    .mute_btn    (mute_btn),
    .s_axis      (mon),
    .gain        (gain),
    .gain_update (gain_update),
    .muted       (muted),
    .ramping     (ramping)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  longint m_gain;
  int     m_mode;   // 0 hold, 1 ramping up, 2 ramping down
  int     m_sw;
  bit     m_muted;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input bit v, input bit r, input bit l);
    mon.frame_valid = v;
    mon.frame_ready = r;
    mon.frame_last  = l;
    tick();
    mon.frame_valid = 1'b0;
    mon.frame_ready = 1'b0;
    mon.frame_last  = 1'b0;
  endtask

  task automatic press_mute();
    mute_btn = 1'b1;
    idle(10);
    mute_btn = 1'b0;
    idle(20);
  endtask

  function automatic longint model_target();
    if (m_muted) return 0;
    if (m_sw == (1 << SW) - 1) return UNITY;
    return longint'(m_sw) * ((UNITY - 1) / ((1 << SW) - 1));
  endfunction

  // One completed frame: leaving hold or reversing costs a frame, else step and clamp.
  task automatic model_frame();
    longint t;
    t = model_target();
    if (m_mode == 0) begin
      if (m_gain < t) m_mode = 1;
      else if (m_gain > t) m_mode = 2;
    end else if (m_mode == 1) begin
      if (t < m_gain) m_mode = 2;
      else if (t == m_gain) m_mode = 0;
      else begin
        m_gain = (m_gain + STEP > t) ? t : m_gain + STEP;
        if (m_gain == t) m_mode = 0;
      end
    end else begin
      if (t > m_gain) m_mode = 1;
      else if (t == m_gain) m_mode = 0;
      else begin
        m_gain = (m_gain - STEP < t) ? t : m_gain - STEP;
        if (m_gain == t) m_mode = 0;
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[6];
    longint exp_g;
    int     pulses;
    bit     v, r, l;
    longint prev;

    vecs[0] = '{sw: 4'hF, exp_gain: 25'h1000000};
    vecs[1] = '{sw: 4'h0, exp_gain: 25'h0000000};
    vecs[2] = '{sw: 4'h8, exp_gain: 25'h0888888};
    vecs[3] = '{sw: 4'h1, exp_gain: 25'h0111111};
    vecs[4] = '{sw: 4'hE, exp_gain: 25'h0EEEEEE};
    vecs[5] = '{sw: 4'h7, exp_gain: 25'h0777777};

    reset = 1'b1;
    sw = '0;
    mute_btn = 1'b0;
    mon.frame_valid = 1'b0;
    mon.frame_ready = 1'b0;
    mon.frame_last  = 1'b0;
    idle(3);
    chk("reset_gain", 64'(gain), 0);
    chk("reset_update", 64'(gain_update), 0);
    chk("reset_muted", 64'(muted), 0);
    chk("reset_ramping", 64'(ramping), 0);
    reset = 1'b0;

    // soft start to unity
    sw = 4'hF;
    idle(20);
    chk("t1_ramping_before", 64'(ramping), 1);
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      beat(1, 1, 1);
      pulses += int'(gain_update);
      chk($sformatf("t1_gain_%0d", k), 64'(gain), 64'((k - 1) * STEP));
    end
    idle(2);
    chk("t1_ramping_after", 64'(ramping), 0);
    chk("t1_pulses", 64'(pulses), 16);
    beat(1, 1, 1);
    chk("t1_no_overshoot", 64'(gain), UNITY);
    chk("t1_idle_update", 64'(gain_update), 0);

    // ramp down to 0x888888 with final clamp
    sw = 4'h8;
    idle(20);
    for (int k = 1; k <= 10; k++) begin
      beat(1, 1, 1);
      exp_g = (k == 1) ? UNITY : UNITY - longint'(k - 1) * STEP;
      if (exp_g < 64'h888888) exp_g = 64'h888888;
      chk($sformatf("t2_gain_%0d", k), 64'(gain), 64'(exp_g));
      chk($sformatf("t2_update_%0d", k), 64'(gain_update), (k >= 2 && k <= 9) ? 1 : 0);
    end

    // short glitch on the switches is rejected
    sw = 4'h3;
    idle(3);
    sw = 4'h8;
    idle(20);
    for (int k = 1; k <= 10; k++) begin
      beat(1, 1, 1);
      chk($sformatf("t3_gain_%0d", k), 64'(gain), 64'h888888);
      chk($sformatf("t3_update_%0d", k), 64'(gain_update), 0);
    end

    // mute ramps to 0, unmute ramps back
    press_mute();
    chk("t4_muted_on", 64'(muted), 1);
    pulses = 0;
    for (int k = 0; k < 15 && gain != 0; k++) begin
      beat(1, 1, 1);
      pulses += int'(gain_update);
    end
    chk("t4_gain_zero", 64'(gain), 0);
    chk("t4_down_pulses", 64'(pulses), 9);
    press_mute();
    chk("t4_muted_off", 64'(muted), 0);
    pulses = 0;
    for (int k = 0; k < 15 && gain != 25'h888888; k++) begin
      beat(1, 1, 1);
      pulses += int'(gain_update);
    end
    chk("t4_gain_back", 64'(gain), 64'h888888);
    chk("t4_up_pulses", 64'(pulses), 9);

    // non-final or stalled beats never move gain
    sw = 4'hF;
    idle(20);
    chk("t5_ramping", 64'(ramping), 1);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) beat(1'($urandom), 1'b0, 1'($urandom));
      else            beat(1'($urandom), 1'b1, 1'b0);
      chk($sformatf("t5_gain_%0d", k), 64'(gain), 64'h888888);
      chk($sformatf("t5_update_%0d", k), 64'(gain_update), 0);
    end

    // reset in the middle of a ramp
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(20);
    for (int k = 0; k < 6; k++) beat(1, 1, 1);
    chk("t6_gain_mid", 64'(gain), 64'h500000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_gain_reset", 64'(gain), 0);
    chk("t6_muted_reset", 64'(muted), 0);
    chk("t6_ramping_reset", 64'(ramping), 0);
    idle(20);
    beat(1, 1, 1);
    chk("t6_restart_hold", 64'(gain), 0);
    beat(1, 1, 1);
    chk("t6_restart_step", 64'(gain), 64'(STEP));

    // switch value to settled gain table
    foreach (vecs[i]) begin
      sw = vecs[i].sw;
      idle(20);
      for (int f = 0; f < 40 && ramping; f++) begin
        beat(1, 1, 1);
        idle(1);
      end
      chk($sformatf("tbl_ramping_%0d", i), 64'(ramping), 0);
      chk($sformatf("tbl_gain_sw%0h", vecs[i].sw), 64'(gain), 64'(vecs[i].exp_gain));
    end

    // randomized traffic against the reference model
    m_gain  = 64'h777777;
    m_mode  = 0;
    m_sw    = 7;
    m_muted = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op <= 15) begin
        v = ($urandom % 4) != 0;
        r = ($urandom % 4) != 0;
        l = ($urandom % 3) != 0;
        prev = m_gain;
        beat(v, r, l);
        if (v && r && l) model_frame();
        chk($sformatf("rnd_gain_%0d", n), 64'(gain), 64'(m_gain));
        chk($sformatf("rnd_update_%0d", n), 64'(gain_update), (m_gain != prev) ? 1 : 0);
      end else if (op <= 17) begin
        m_sw = int'($urandom_range(0, 15));
        sw = SW'(m_sw);
        idle(20);
      end else if (op == 18) begin
        press_mute();
        m_muted = ~m_muted;
        chk($sformatf("rnd_muted_%0d", n), 64'(muted), 64'(m_muted));
      end else begin
        idle(int'($urandom_range(1, 5)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
